// File: rtl/rtu_rsp_parser.sv
// Modbus RTU master-side response parser: validates a slave reply against the armed request.
// Status and fields appear with a one-cycle rsp_valid; read registers stream out one per cycle.
module rtu_rsp_parser #(
    parameter int MAX_REGS     = 4,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [7:0]  exp_addr,
    input  logic [7:0]  exp_func,
    input  logic [7:0]  exp_qty,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_drop_frame,
    input  logic        rx_new_frame,
    output logic        busy,
    output logic        reg_wen,
    output logic [7:0]  reg_idx,
    output logic [15:0] reg_wdata,
    output logic [15:0] echo_addr,
    output logic [15:0] echo_data,
    output logic [7:0]  exc_code,
    output logic [2:0]  rsp_status,
    output logic        rsp_valid
);

    typedef enum logic [2:0] {IDLE, WAIT_FIRST, RX, CHECK, DRAIN, DONE} state_t;

    localparam logic [2:0] ST_OK   = 3'd0;
    localparam logic [2:0] ST_EXC  = 3'd1;
    localparam logic [2:0] ST_CRC  = 3'd2;
    localparam logic [2:0] ST_FMT  = 3'd3;
    localparam logic [2:0] ST_TMO  = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  status_q, status_d;
    logic [7:0]  exp_addr_q, exp_func_q, exp_qty_q;
    logic [7:0]  cnt_q, idx_q, exc_code_q;
    logic [15:0] crc_q, echo_addr_q, echo_data_q;
    logic [31:0] tmo_q;
    logic        fmt_q, exc_q;
    logic [15:0] buf_q [MAX_REGS];

    logic        is_read, req_bad, take_arm, take_byte, frame_done;
    logic [8:0]  exp_len, qty_x2;
    logic [7:0]  cnt_next, data_pos;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        is_read    = (exp_func_q == 8'h03) || (exp_func_q == 8'h04);
        qty_x2     = {exp_qty_q, 1'b0};
        req_bad    = !(is_read || exp_func_q == 8'h06) ||
                     (is_read && (exp_qty_q == 8'd0 || int'(exp_qty_q) > MAX_REGS));
        exp_len    = exc_q ? 9'd5 : ((exp_func_q == 8'h06) ? 9'd8 : 9'd5 + qty_x2);
        cnt_next   = cnt_q + 8'd1;
        data_pos   = cnt_q - 8'd3;
        take_arm   = (state_q == IDLE) && arm;
        // A drop in the same cycle as a byte discards that byte.
        take_byte  = rx_done && !rx_drop_frame && !req_bad &&
                     (state_q == WAIT_FIRST || state_q == RX);
        frame_done = take_byte && ({1'b0, cnt_next} == exp_len);
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            IDLE: if (arm) state_d = WAIT_FIRST;
            // The latched request is vetted here so a bad request still answers 2 cycles after arm.
            WAIT_FIRST: begin
                if (req_bad) begin
                    state_d  = DONE;
                    status_d = ST_FMT;
                end else if (take_byte) begin
                    state_d = RX;
                end else if (tmo_q == 32'(TIMEOUT_CLKS - 1)) begin
                    state_d  = DONE;
                    status_d = ST_TMO;
                end
            end
            RX: begin
                if (rx_drop_frame) begin
                    state_d  = DONE;
                    status_d = ST_DROP;
                end else if (frame_done) begin
                    state_d = CHECK;
                end else if (rx_new_frame) begin
                    state_d  = DONE;
                    status_d = ST_FMT;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (crc_q != 16'h0000)       status_d = ST_CRC;
                else if (fmt_q)              status_d = ST_FMT;
                else if (exc_q)              status_d = ST_EXC;
                else if (is_read)            state_d  = DRAIN;
                else                         status_d = ST_OK;
            end
            DRAIN: begin
                if (idx_q == exp_qty_q - 8'd1) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            status_q    <= ST_OK;
            exp_addr_q  <= '0;
            exp_func_q  <= '0;
            exp_qty_q   <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            exc_code_q  <= '0;
            crc_q       <= '0;
            echo_addr_q <= '0;
            echo_data_q <= '0;
            tmo_q       <= '0;
            fmt_q       <= 1'b0;
            exc_q       <= 1'b0;
            for (int i = 0; i < MAX_REGS; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == WAIT_FIRST) tmo_q <= tmo_q + 32'd1;
            if (state_q == DRAIN)      idx_q <= idx_q + 8'd1;
            if (take_arm) begin
                exp_addr_q  <= exp_addr;
                exp_func_q  <= exp_func;
                exp_qty_q   <= exp_qty;
                cnt_q       <= '0;
                idx_q       <= '0;
                tmo_q       <= '0;
                crc_q       <= 16'hFFFF;
                fmt_q       <= 1'b0;
                exc_q       <= 1'b0;
                status_q    <= ST_OK;
                echo_addr_q <= '0;
                echo_data_q <= '0;
                exc_code_q  <= '0;
            end
            if (take_byte) begin
                crc_q <= crc_upd(crc_q, rx_data);
                cnt_q <= cnt_next;
                if (cnt_q == 8'd0) begin
                    if (rx_data != exp_addr_q) fmt_q <= 1'b1;
                end else if (cnt_q == 8'd1) begin
                    if (rx_data == (exp_func_q | 8'h80)) exc_q <= 1'b1;
                    else if (rx_data != exp_func_q)      fmt_q <= 1'b1;
                end else if (exc_q) begin
                    if (cnt_q == 8'd2) exc_code_q <= rx_data;
                end else if (!is_read) begin
                    case (cnt_q)
                        8'd2:    echo_addr_q[15:8] <= rx_data;
                        8'd3:    echo_addr_q[7:0]  <= rx_data;
                        8'd4:    echo_data_q[15:8] <= rx_data;
                        8'd5:    echo_data_q[7:0]  <= rx_data;
                        default: ;
                    endcase
                end else if (cnt_q == 8'd2) begin
                    if ({1'b0, rx_data} != qty_x2) fmt_q <= 1'b1;
                end else if ({1'b0, data_pos} < qty_x2) begin
                    for (int i = 0; i < MAX_REGS; i++) begin
                        if (data_pos[7:1] == 7'(i)) begin
                            if (data_pos[0]) buf_q[i][7:0]  <= rx_data;
                            else             buf_q[i][15:8] <= rx_data;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        reg_wdata = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            if (reg_wen && idx_q == 8'(i)) reg_wdata = buf_q[i];
        end
    end

    assign reg_wen    = (state_q == DRAIN);
    assign reg_idx    = reg_wen ? idx_q : 8'd0;
    assign busy       = (state_q == WAIT_FIRST) || (state_q == RX) ||
                        (state_q == CHECK) || (state_q == DRAIN);
    assign rsp_valid  = (state_q == DONE);
    assign rsp_status = status_q;
    assign echo_addr  = echo_addr_q;
    assign echo_data  = echo_data_q;
    assign exc_code   = exc_code_q;

endmodule

// File: tb/tb_rtu_rsp_parser.sv
// Bench for rtu_rsp_parser: directed Modbus frames plus randomized frames checked against a frame-level model.
module tb_rtu_rsp_parser;
    localparam int TMO = 300;
    localparam logic [2:0] S_OK = 3'd0, S_EXC = 3'd1, S_CRC = 3'd2, S_FMT = 3'd3, S_TMO = 3'd4, S_DROP = 3'd5;

    logic        clk = 1'b0;
    logic        rst, arm, rx_done, rx_drop_frame, rx_new_frame;
    logic [7:0]  exp_addr, exp_func, exp_qty, rx_data;
    logic        busy, reg_wen, rsp_valid;
    logic [7:0]  reg_idx, exc_code;
    logic [15:0] reg_wdata, echo_addr, echo_data;
    logic [2:0]  rsp_status;

    int n_chk = 0, n_fail = 0, cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    logic [2:0]  got_st;
    logic [15:0] got_ea, got_ed;
    logic [7:0]  got_exc;
    logic [23:0] regq[$];
    logic [7:0]  fr[$];
    bit          rearm_mid = 0;

    rtu_rsp_parser #(.MAX_REGS(4), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .exp_addr(exp_addr), .exp_func(exp_func), .exp_qty(exp_qty),
        .rx_done(rx_done), .rx_data(rx_data),
        .rx_drop_frame(rx_drop_frame), .rx_new_frame(rx_new_frame),
        .busy(busy), .reg_wen(reg_wen), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
        .echo_addr(echo_addr), .echo_data(echo_data), .exc_code(exc_code),
        .rsp_status(rsp_status), .rsp_valid(rsp_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wen) regq.push_back({reg_idx, reg_wdata});
        if (rsp_valid) begin
            rsp_cnt = rsp_cnt + 1;
            rsp_cyc = cyc;
            got_st  = rsp_status;
            got_ea  = echo_addr;
            got_ed  = echo_data;
            got_exc = exc_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input int upto);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < upto; i++) begin
            c = c ^ {8'h00, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic append_crc();
        logic [15:0] c;
        c = crc16(fr.size());
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
    endtask

    // term: 0 none, 1 new_frame after, 2 drop after, 3 drop together with a byte, 4 new_frame with last byte
    task automatic run_txn(input logic [7:0] a, input logic [7:0] f, input logic [7:0] q,
                           input int term, input string tag);
        logic [2:0] st;
        int n, len, ref_cyc, exp_lat, lat, base, nreg;
        bit bad, rd, exc, fmt, seen;
        n   = fr.size();
        rd  = (f == 8'h03) || (f == 8'h04);
        bad = !(rd || f == 8'h06) || (rd && (q == 0 || q > 4));
        exc = (n >= 2) && (fr[1] == (f | 8'h80));
        len = exc ? 5 : ((f == 8'h06) ? 8 : 5 + 2 * int'(q));
        if (bad)           st = S_FMT;
        else if (n == 0)   st = S_TMO;
        else if (n < len)  st = (term == 2 || term == 3) ? S_DROP : S_FMT;
        else if (crc16(len) != 16'h0000) st = S_CRC;
        else begin
            fmt = (fr[0] != a) || !(exc || fr[1] == f) || (!exc && rd && fr[2] != 8'(2 * int'(q)));
            st  = fmt ? S_FMT : (exc ? S_EXC : S_OK);
        end
        nreg    = (st == S_OK && rd) ? int'(q) : 0;
        exp_lat = (bad || n >= len) ? 2 + nreg : 1;

        base = rsp_cnt;
        regq.delete();
        @(negedge clk);
        exp_addr = a; exp_func = f; exp_qty = q; arm = 1'b1; ref_cyc = cyc;
        @(negedge clk);
        arm = 1'b0;
        chk({tag, "/busy"}, 32'(busy), 1);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                rx_data = fr[i]; rx_done = 1'b1;
                if (i == len - 1 || (term == 4 && i == n - 1 && n < len)) ref_cyc = cyc;
                if (term == 4 && i == n - 1) rx_new_frame = 1'b1;
                @(negedge clk);
                rx_done = 1'b0; rx_new_frame = 1'b0;
                if (rearm_mid && i == 2) begin
                    exp_func = 8'h10; arm = 1'b1;
                    @(negedge clk);
                    arm = 1'b0; exp_func = f;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (term >= 1 && term <= 3) begin
                @(negedge clk);
                if (n < len) ref_cyc = cyc;
                if (term == 1) rx_new_frame = 1'b1; else rx_drop_frame = 1'b1;
                if (term == 3) begin rx_done = 1'b1; rx_data = 8'hA5; end
                @(negedge clk);
                rx_new_frame = 1'b0; rx_drop_frame = 1'b0; rx_done = 1'b0;
            end
        end
        #1;
        seen = (rsp_cnt != base);
        for (int k = 0; k < TMO + 100 && !seen; k++) begin
            @(negedge clk); #1;
            seen = (rsp_cnt != base);
        end
        if (!seen) begin
            chk({tag, "/rsp_seen"}, 0, 1);
        end else begin
            chk({tag, "/status"}, 32'(got_st), 32'(st));
            lat = rsp_cyc - ref_cyc;
            if (st == S_TMO) chk({tag, "/tmo_lat_in_range"}, 32'(lat >= TMO && lat <= TMO + 2), 1);
            else             chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "/nregs"}, 32'(regq.size()), 32'(nreg));
            for (int i = 0; i < nreg && i < regq.size(); i++)
                chk({tag, "/reg"}, 32'(regq[i]), {8'h00, 8'(i), fr[3 + 2 * i], fr[4 + 2 * i]});
            if (st == S_OK && f == 8'h06) begin
                chk({tag, "/echo_addr"}, 32'(got_ea), {16'h0, fr[2], fr[3]});
                chk({tag, "/echo_data"}, 32'(got_ed), {16'h0, fr[4], fr[5]});
            end
            if (st == S_EXC) chk({tag, "/exc_code"}, 32'(got_exc), 32'(fr[2]));
        end
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "/one_pulse"}, 32'(rsp_cnt - base), 1);
        chk({tag, "/idle"}, {29'h0, busy, reg_wen, rsp_valid}, 0);
        chk({tag, "/status_hold"}, 32'(rsp_status), 32'(st));
    endtask

    task automatic gen_rand(output logic [7:0] a, output logic [7:0] f, output logic [7:0] q, output int term);
        int pick, mode, idx, cut;
        bit ex;
        fr.delete();
        a    = 8'($urandom_range(1, 247));
        pick = $urandom_range(0, 9);
        f    = (pick < 4) ? 8'h03 : ((pick < 7) ? 8'h04 : 8'h06);
        q    = 8'($urandom_range(1, 4));
        ex   = ($urandom_range(0, 4) == 0);
        mode = $urandom_range(0, 5);
        fr.push_back((mode == 4) ? (a ^ 8'h01) : a);
        if (ex) begin
            fr.push_back(f | 8'h80);
            fr.push_back(8'($urandom_range(1, 11)));
        end else if (f == 8'h06) begin
            fr.push_back(f);
            repeat (4) fr.push_back(8'($urandom));
        end else begin
            fr.push_back(f);
            fr.push_back(8'(2 * int'(q)));
            repeat (2 * int'(q)) fr.push_back(8'($urandom));
        end
        append_crc();
        if (mode == 3) begin
            idx = $urandom_range(0, fr.size() - 1);
            fr[idx] = fr[idx] ^ 8'($urandom_range(1, 255));
        end
        term = ($urandom_range(0, 1) == 1) ? 1 : 4;
        if (mode == 5) begin
            cut = $urandom_range(1, fr.size() - 1);
            while (fr.size() > cut) void'(fr.pop_back());
            term = $urandom_range(1, 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, f, q;
        int term, base;
        rst = 1'b1; arm = 1'b0; rx_done = 1'b0; rx_drop_frame = 1'b0; rx_new_frame = 1'b0;
        exp_addr = '0; exp_func = '0; exp_qty = '0; rx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset/ctl", {29'h0, busy, reg_wen, rsp_valid}, 0);
        chk("reset/fields", {echo_addr, echo_data} | {16'h0, reg_wdata} | {24'h0, exc_code}, 0);
        chk("reset/status", {21'h0, reg_idx, rsp_status}, 0);
        rst = 1'b0;

        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_txn(8'h01, 8'h06, 8'h00, 1, "write_echo");
        fr = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h51}; append_crc();
        run_txn(8'h01, 8'h03, 8'h01, 1, "read1");
        fr = '{8'h01, 8'h04, 8'h08, 8'h53, 8'h47, 8'h74, 8'h14, 8'h20, 8'h21, 8'h04, 8'h02}; append_crc();
        run_txn(8'h01, 8'h04, 8'h04, 1, "read4");
        fr = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        run_txn(8'h01, 8'h03, 8'h01, 1, "exception");
        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0C};
        run_txn(8'h01, 8'h06, 8'h00, 1, "crc_err");
        fr = '{8'h02, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03}; append_crc();
        run_txn(8'h01, 8'h06, 8'h00, 1, "bad_addr");
        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00};
        run_txn(8'h01, 8'h06, 8'h00, 1, "short_frame");
        fr.delete();
        run_txn(8'h01, 8'h06, 8'h00, 0, "timeout");
        fr = '{8'h01, 8'h06, 8'h00};
        run_txn(8'h01, 8'h06, 8'h00, 2, "dropped");
        fr = '{8'h01, 8'h06, 8'h00, 8'h01};
        run_txn(8'h01, 8'h06, 8'h00, 3, "drop_with_byte");
        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_txn(8'h01, 8'h06, 8'h00, 4, "newframe_with_last");
        rearm_mid = 1;
        run_txn(8'h01, 8'h06, 8'h00, 1, "rearm_ignored");
        rearm_mid = 0;
        fr.delete();
        run_txn(8'h01, 8'h10, 8'h01, 0, "bad_func");
        run_txn(8'h01, 8'h03, 8'h00, 0, "qty_zero");
        run_txn(8'h01, 8'h04, 8'h05, 0, "qty_over");

        // reset in the middle of a frame
        base = rsp_cnt;
        @(negedge clk);
        exp_addr = 8'h01; exp_func = 8'h06; exp_qty = 8'h00; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        fr = '{8'h01, 8'h06, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) begin
            rx_data = fr[i]; rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/ctl", {29'h0, busy, reg_wen, rsp_valid}, 0);
        chk("midrst/echo", {echo_addr, echo_data}, 0);
        chk("midrst/status", {21'h0, reg_idx, rsp_status}, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("midrst/no_rsp", 32'(rsp_cnt - base), 0);
        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_txn(8'h01, 8'h06, 8'h00, 1, "after_rst");

        for (int t = 0; t < 60; t++) begin
            gen_rand(a, f, q, term);
            run_txn(a, f, q, term, "rand");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
